pipe_ctrl_chain: RTL and testbench
==================================

Name: pipe_ctrl_chain

Overview:
- Carries decoded control fields from decode (ID) down the EXE, MEM and WB stage registers of the 5-stage pipeline.
- Presents the in-flight destination/write-enable information back to the decode-side control unit, which uses it for forwarding and stall decisions.
- Inserts bubbles on decode stall, squashes on branch/jump flush, and freezes on memory hold.
- Producer side of the e_/m_ signals that the control unit consumes.

Parameters:
- ALU_W, 4, width of ALU control field (matches `ALUBus`)
- REG_W, 5, width of register address field (matches `RsRtRdBus`)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- id_valid  in  1  decode slot holds a real instruction
- id_write_reg / id_mem_to_reg / id_write_mem  in  1 each  decoded controls
- id_aluc  in  ALU_W  decoded ALU op
- id_shift / id_alu_imm / id_sext_signed  in  1 each  decoded operand controls
- id_des_r  in  REG_W  destination register (rt or rd, already selected)
- stall  in  1  decode stall (inverse of write_pc_ir); inject bubble into EXE
- flush  in  1  squash instruction entering EXE (taken branch/jump)
- hold  in  1  memory wait; freeze all stage registers
- e_valid, e_write_reg, e_mem_to_reg, e_write_mem, e_shift, e_alu_imm, e_sext_signed  out  1 each  EXE stage controls
- e_aluc  out  ALU_W  EXE ALU op
- e_des_r  out  REG_W  EXE destination
- m_valid, m_write_reg, m_mem_to_reg, m_write_mem  out  1 each  MEM stage controls
- m_des_r  out  REG_W  MEM destination
- w_valid, w_write_reg, w_mem_to_reg  out  1 each  WB stage controls
- w_des_r  out  REG_W  WB destination

Behaviour:
- Reset, async on rst rising, held while rst=1:
  - Every output is 0.
  - The internal pend_flush register is 0.
- Normal advance, rising clk with hold=0:
  - W<=M and M<=E (subset of fields).
  - E<=ID fields when id_valid=1, stall=0, flush=0 and pend_flush=0; otherwise E<=bubble.
- Bubble: every valid/enable bit 0, aluc=0, des_r=0.
- Latency: an ID field is visible at e_* 1 cycle after capture, at m_* after 2 cycles, at w_* after 3 cycles (hold cycles excluded).
- $zero rule: on capture into E, if id_des_r==0 then e_write_reg is forced 0. Other fields are captured unchanged.
- Priority: hold > flush > stall.
- Hold=1:
  - All three stages keep their values.
  - If flush=1 in the same cycle, set pend_flush=1.
  - Outputs stay stable.
- First cycle with hold=0 and pend_flush=1: E gets a bubble and pend_flush clears. A flush asserted in that same cycle is satisfied by this one bubble, not doubled.
- stall and flush together with hold=0: a single bubble into E; M and W advance normally.
- Bubbles are counted as instructions with valid=0; downstream enables are already 0.
- Reset mid-hold or with a pending flush: everything clears and pend_flush=0.
- Purely registered outputs; no combinational path from inputs to outputs.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined, three extra outputs, each 32 bits:
  - retire_cnt: increments when hold=0 and w_valid=1 at the clk edge, i.e. an instruction leaves WB.
  - bubble_cnt: increments on each hold=0 edge that loads a bubble into E.
  - hold_cnt: increments on each edge with hold=1.
- All counters reset to 0 and wrap modulo 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared macros header holds `ALUBus`, `RsRtRdBus`, `True`/`False`, and a new `ZeroReg` constant (0).
- Natural sub-module: pipe_stage_reg, one generic stage register with data-in, enable (=~hold) and a bubble select.
  - Instantiated three times with different field widths.
  - Owns the reset and bubble value.
- Top level holds pend_flush and the optional counters.

Test Plan:
- Reset release, then id_valid=1, id_write_reg=1, id_des_r=8, id_aluc=2 for one cycle → e_des_r=8 at cycle+1, m_des_r=8 at cycle+2, w_des_r=8 with w_write_reg=1 at cycle+3; all zero afterwards.
- id_des_r=0 with id_write_reg=1 → e_write_reg=0, e_valid=1.
- stall=1 for 1 cycle within a stream of instructions with des 1,2,3 → E shows a bubble between 1 and 2, and m_* shows the same gap one cycle later.
- hold=1 for 3 cycles with flush=1 on the 2nd → stage outputs frozen for 3 cycles; the first cycle after hold loads a bubble into E; pend_flush cleared after it.
- rst asserted asynchronously mid-hold with pend_flush=1 → all outputs 0 immediately (before next clk); after release the first valid ID is captured normally with no stale bubble.
- PIPE_PERF_CNT_EN defined: 10 valid instructions, 2 stalls, 3 hold cycles → retire_cnt=10 after the drain, bubble_cnt=2, hold_cnt=3.

Source files
------------

// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared constants for the ID->EXE->MEM->WB control chain: bus widths, boolean
// levels and the hard-wired $zero register index.
package pipe_ctrl_chain_pkg;

    localparam int   ALU_BUS_W      = 4;
    localparam int   RS_RT_RD_BUS_W = 5;
    localparam logic TRUE           = 1'b1;
    localparam logic FALSE          = 1'b0;
    localparam int   ZERO_REG       = 0;

    // Writes to $zero are architecturally discarded, so they never count as a producer.
    function automatic logic is_zero_reg(input logic [31:0] reg_idx);
        return (reg_idx == 32'(ZERO_REG));
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: loads data when enabled, or all-zero on bubble/reset.
module pipe_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Stage capture; all-zero is both the reset value and the bubble encoding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= {W{1'b0}};
        end else if (en) begin
            if (bubble) begin
                q <= {W{1'b0}};
            end else begin
                q <= d;
            end
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Control-field chain ID->EXE->MEM->WB with stall bubbles, flush squash and hold freeze.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl_chain
    import pipe_ctrl_chain_pkg::*;
#(
    parameter int ALU_W = ALU_BUS_W,
    parameter int REG_W = RS_RT_RD_BUS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_write_reg,
    input  logic             id_mem_to_reg,
    input  logic             id_write_mem,
    input  logic [ALU_W-1:0] id_aluc,
    input  logic             id_shift,
    input  logic             id_alu_imm,
    input  logic             id_sext_signed,
    input  logic [REG_W-1:0] id_des_r,
    input  logic             stall,
    input  logic             flush,
    input  logic             hold,
    output logic             e_valid,
    output logic             e_write_reg,
    output logic             e_mem_to_reg,
    output logic             e_write_mem,
    output logic             e_shift,
    output logic             e_alu_imm,
    output logic             e_sext_signed,
    output logic [ALU_W-1:0] e_aluc,
    output logic [REG_W-1:0] e_des_r,
    output logic             m_valid,
    output logic             m_write_reg,
    output logic             m_mem_to_reg,
    output logic             m_write_mem,
    output logic [REG_W-1:0] m_des_r,
    output logic             w_valid,
    output logic             w_write_reg,
    output logic             w_mem_to_reg,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0]      retire_cnt,
    output logic [31:0]      bubble_cnt,
    output logic [31:0]      hold_cnt,
`endif
    output logic [REG_W-1:0] w_des_r
);

    localparam int E_W = 7 + ALU_W + REG_W;
    localparam int M_W = 4 + REG_W;
    localparam int W_W = 3 + REG_W;

    logic           pend_flush_r;
    logic           adv_s;
    logic           e_load_s;
    logic           e_write_reg_s;
    logic [E_W-1:0] e_d_s;
    logic [E_W-1:0] e_q_s;
    logic [M_W-1:0] m_d_s;
    logic [M_W-1:0] m_q_s;
    logic [W_W-1:0] w_d_s;
    logic [W_W-1:0] w_q_s;

    assign adv_s         = ~hold;
    // A flush that arrived during hold is honoured by the first bubble after release.
    assign e_load_s      = id_valid & ~stall & ~flush & ~pend_flush_r;
    assign e_write_reg_s = id_write_reg & ~is_zero_reg(32'(id_des_r));

    assign e_d_s = {id_valid, e_write_reg_s, id_mem_to_reg, id_write_mem,
                    id_shift, id_alu_imm, id_sext_signed, id_aluc, id_des_r};
    assign m_d_s = {e_valid, e_write_reg, e_mem_to_reg, e_write_mem, e_des_r};
    assign w_d_s = {m_valid, m_write_reg, m_mem_to_reg, m_des_r};

    assign {e_valid, e_write_reg, e_mem_to_reg, e_write_mem,
            e_shift, e_alu_imm, e_sext_signed, e_aluc, e_des_r} = e_q_s;
    assign {m_valid, m_write_reg, m_mem_to_reg, m_write_mem, m_des_r} = m_q_s;
    assign {w_valid, w_write_reg, w_mem_to_reg, w_des_r} = w_q_s;

    pipe_stage_reg #(.W(E_W)) u_exe_reg (
        .clk(clk), .rst(rst), .en(adv_s), .bubble(~e_load_s), .d(e_d_s), .q(e_q_s)
    );

    pipe_stage_reg #(.W(M_W)) u_mem_reg (
        .clk(clk), .rst(rst), .en(adv_s), .bubble(FALSE), .d(m_d_s), .q(m_q_s)
    );

    pipe_stage_reg #(.W(W_W)) u_wb_reg (
        .clk(clk), .rst(rst), .en(adv_s), .bubble(FALSE), .d(w_d_s), .q(w_q_s)
    );

    // Remember a flush seen while frozen; any advancing edge consumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_flush_r <= FALSE;
        end else if (hold) begin
            if (flush) begin
                pend_flush_r <= TRUE;
            end else begin
                pend_flush_r <= pend_flush_r;
            end
        end else begin
            pend_flush_r <= FALSE;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic forced_bubble_s;

    // Only bubbles forced by stall/flush count; idle decode slots are not bubbles.
    assign forced_bubble_s = adv_s & (stall | flush | pend_flush_r);

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= 32'd0;
            bubble_cnt <= 32'd0;
            hold_cnt   <= 32'd0;
        end else begin
            retire_cnt <= retire_cnt + ((adv_s & w_valid) ? 32'd1 : 32'd0);
            bubble_cnt <= bubble_cnt + (forced_bubble_s ? 32'd1 : 32'd0);
            hold_cnt   <= hold_cnt + (hold ? 32'd1 : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Self-checking bench for pipe_ctrl_chain: directed scenarios plus a retire scoreboard
// that matches each instruction leaving WB against the expected program order.
module tb_pipe_ctrl_chain;

    logic       clk = 1'b0;
    logic       rst, id_valid, id_write_reg, id_mem_to_reg, id_write_mem;
    logic [3:0] id_aluc;
    logic       id_shift, id_alu_imm, id_sext_signed;
    logic [4:0] id_des_r;
    logic       stall, flush, hold;
    logic       e_valid, e_write_reg, e_mem_to_reg, e_write_mem, e_shift, e_alu_imm, e_sext_signed;
    logic [3:0] e_aluc;
    logic [4:0] e_des_r;
    logic       m_valid, m_write_reg, m_mem_to_reg, m_write_mem;
    logic [4:0] m_des_r;
    logic       w_valid, w_write_reg, w_mem_to_reg;
    logic [4:0] w_des_r;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] retire_cnt, bubble_cnt, hold_cnt;
`endif

    logic [32:0] all_out;
    assign all_out = {e_valid, e_write_reg, e_mem_to_reg, e_write_mem, e_shift, e_alu_imm,
                      e_sext_signed, e_aluc, e_des_r, m_valid, m_write_reg, m_mem_to_reg,
                      m_write_mem, m_des_r, w_valid, w_write_reg, w_mem_to_reg, w_des_r};

    int checks   = 0;
    int failures = 0;
    logic [6:0] exp_q[$];
    logic hold_at_edge;

    pipe_ctrl_chain dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_write_reg(id_write_reg),
        .id_mem_to_reg(id_mem_to_reg), .id_write_mem(id_write_mem), .id_aluc(id_aluc),
        .id_shift(id_shift), .id_alu_imm(id_alu_imm), .id_sext_signed(id_sext_signed),
        .id_des_r(id_des_r), .stall(stall), .flush(flush), .hold(hold),
        .e_valid(e_valid), .e_write_reg(e_write_reg), .e_mem_to_reg(e_mem_to_reg),
        .e_write_mem(e_write_mem), .e_shift(e_shift), .e_alu_imm(e_alu_imm),
        .e_sext_signed(e_sext_signed), .e_aluc(e_aluc), .e_des_r(e_des_r),
        .m_valid(m_valid), .m_write_reg(m_write_reg), .m_mem_to_reg(m_mem_to_reg),
        .m_write_mem(m_write_mem), .m_des_r(m_des_r),
        .w_valid(w_valid), .w_write_reg(w_write_reg), .w_mem_to_reg(w_mem_to_reg),
`ifdef PIPE_PERF_CNT_EN
        .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt),
`endif
        .w_des_r(w_des_r)
    );

    always #5 clk = ~clk;

    // One clock; after a non-hold edge a valid WB occupant is a fresh retirement.
    task automatic step();
        hold_at_edge = hold;
        @(posedge clk);
        #1;
        if (!hold_at_edge && w_valid) begin : sb
            logic [6:0] exp_v;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_retire unexpected retirement des=%0d", w_des_r);
            end else begin
                exp_v = exp_q.pop_front();
                if ({w_write_reg, w_mem_to_reg, w_des_r} !== exp_v) begin
                    failures++;
                    $display("FAIL sb_retire got wr/m2r/des=%b required %b",
                             {w_write_reg, w_mem_to_reg, w_des_r}, exp_v);
                end
            end
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] des, input logic wr, input logic m2r);
        id_valid       = v;
        id_des_r       = des;
        id_write_reg   = wr;
        id_mem_to_reg  = m2r;
        id_write_mem   = des[4];
        id_aluc        = des[3:0];
        id_shift       = des[0];
        id_alu_imm     = des[1];
        id_sext_signed = des[2];
    endtask

    task automatic drain_and_check(input string name);
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_sb_empty remaining=%0d required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; hold = 1'b0;
        set_id(1'b1, 5'd7, 1'b1, 1'b1);
        step(); step();
        checks++;
        if (all_out !== 33'd0) begin
            failures++; $display("FAIL reset_outputs got %h required 0", all_out);
        end
        rst = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 1'b0);
        step();
        checks++;
        if (all_out !== 33'd0) begin
            failures++; $display("FAIL reset_idle got %h required 0", all_out);
        end
    endtask

    task automatic test_latency();
        exp_q.push_back({1'b1, 1'b0, 5'd8});
        set_id(1'b1, 5'd8, 1'b1, 1'b0);
        id_aluc = 4'd2;
        step();
        checks++;
        if ({e_valid, e_write_reg, e_aluc, e_des_r} !== {1'b1, 1'b1, 4'd2, 5'd8}) begin
            failures++;
            $display("FAIL lat_e got v/wr/aluc/des=%b required %b",
                     {e_valid, e_write_reg, e_aluc, e_des_r}, {1'b1, 1'b1, 4'd2, 5'd8});
        end
        set_id(1'b0, 5'd0, 1'b0, 1'b0);
        step();
        checks++;
        if ({m_valid, m_write_reg, m_des_r, e_valid} !== {1'b1, 1'b1, 5'd8, 1'b0}) begin
            failures++;
            $display("FAIL lat_m got %b required %b", {m_valid, m_write_reg, m_des_r, e_valid},
                     {1'b1, 1'b1, 5'd8, 1'b0});
        end
        step();
        checks++;
        if ({w_valid, w_write_reg, w_des_r} !== {1'b1, 1'b1, 5'd8}) begin
            failures++;
            $display("FAIL lat_w got %b required %b", {w_valid, w_write_reg, w_des_r}, {1'b1, 1'b1, 5'd8});
        end
        step();
        checks++;
        if (all_out !== 33'd0) begin
            failures++; $display("FAIL lat_empty got %h required 0", all_out);
        end
        drain_and_check("lat");
    endtask

    task automatic test_zero_reg();
        exp_q.push_back({1'b0, 1'b1, 5'd0});
        set_id(1'b1, 5'd0, 1'b1, 1'b1);
        step();
        checks++;
        if ({e_valid, e_write_reg, e_mem_to_reg} !== 3'b101) begin
            failures++;
            $display("FAIL zero_reg_e got v/wr/m2r=%b required 101", {e_valid, e_write_reg, e_mem_to_reg});
        end
        set_id(1'b0, 5'd0, 1'b0, 1'b0);
        step();
        checks++;
        if ({m_valid, m_write_reg} !== 2'b10) begin
            failures++; $display("FAIL zero_reg_m got v/wr=%b required 10", {m_valid, m_write_reg});
        end
        drain_and_check("zero_reg");
    endtask

    task automatic test_stall();
        exp_q.push_back({1'b1, 1'b0, 5'd1});
        exp_q.push_back({1'b1, 1'b0, 5'd2});
        exp_q.push_back({1'b1, 1'b0, 5'd3});
        set_id(1'b1, 5'd1, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd2, 1'b1, 1'b0);
        stall = 1'b1;
        step();
        checks++;
        if ({e_valid, e_des_r, m_valid, m_des_r} !== {1'b0, 5'd0, 1'b1, 5'd1}) begin
            failures++;
            $display("FAIL stall_bubble_e got %b required %b", {e_valid, e_des_r, m_valid, m_des_r},
                     {1'b0, 5'd0, 1'b1, 5'd1});
        end
        stall = 1'b0;
        step();
        checks++;
        if ({e_valid, e_des_r, m_valid} !== {1'b1, 5'd2, 1'b0}) begin
            failures++;
            $display("FAIL stall_gap_m got %b required %b", {e_valid, e_des_r, m_valid}, {1'b1, 5'd2, 1'b0});
        end
        set_id(1'b1, 5'd3, 1'b1, 1'b0);
        step();
        checks++;
        if ({e_des_r, m_des_r, w_valid} !== {5'd3, 5'd2, 1'b0}) begin
            failures++;
            $display("FAIL stall_gap_w got %b required %b", {e_des_r, m_des_r, w_valid}, {5'd3, 5'd2, 1'b0});
        end
        set_id(1'b0, 5'd0, 1'b0, 1'b0);
        drain_and_check("stall");
    endtask

    task automatic test_hold_flush();
        exp_q.push_back({1'b1, 1'b0, 5'd4});
        exp_q.push_back({1'b1, 1'b0, 5'd5});
        exp_q.push_back({1'b1, 1'b0, 5'd6});
        exp_q.push_back({1'b1, 1'b0, 5'd7});
        exp_q.push_back({1'b1, 1'b0, 5'd9});
        for (int d = 4; d <= 6; d++) begin
            set_id(1'b1, 5'(d), 1'b1, 1'b0);
            step();
        end
        set_id(1'b1, 5'd7, 1'b1, 1'b0);
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            flush = (c == 1);
            step();
            checks++;
            if ({e_valid, e_des_r, m_des_r, w_des_r} !== {1'b1, 5'd6, 5'd5, 5'd4}) begin
                failures++;
                $display("FAIL hold_frozen cyc=%0d got %b required %b", c,
                         {e_valid, e_des_r, m_des_r, w_des_r}, {1'b1, 5'd6, 5'd5, 5'd4});
            end
        end
        flush = 1'b0;
        hold  = 1'b0;
        step();
        checks++;
        if ({e_valid, e_des_r, m_des_r, w_des_r} !== {1'b0, 5'd0, 5'd6, 5'd5}) begin
            failures++;
            $display("FAIL pend_flush_bubble got %b required %b",
                     {e_valid, e_des_r, m_des_r, w_des_r}, {1'b0, 5'd0, 5'd6, 5'd5});
        end
        step();
        checks++;
        if ({e_valid, e_des_r} !== {1'b1, 5'd7}) begin
            failures++;
            $display("FAIL pend_flush_cleared got %b required %b", {e_valid, e_des_r}, {1'b1, 5'd7});
        end
        set_id(1'b1, 5'd8, 1'b1, 1'b0);
        hold  = 1'b1;
        flush = 1'b1;
        step();
        hold  = 1'b0;
        stall = 1'b1;
        step();
        checks++;
        if ({e_valid, e_des_r} !== {1'b0, 5'd0}) begin
            failures++;
            $display("FAIL flush_stall_single_bubble got %b required %b", {e_valid, e_des_r}, {1'b0, 5'd0});
        end
        flush = 1'b0;
        stall = 1'b0;
        set_id(1'b1, 5'd9, 1'b1, 1'b0);
        step();
        checks++;
        if ({e_valid, e_des_r} !== {1'b1, 5'd9}) begin
            failures++;
            $display("FAIL flush_not_doubled got %b required %b", {e_valid, e_des_r}, {1'b1, 5'd9});
        end
        set_id(1'b0, 5'd0, 1'b0, 1'b0);
        drain_and_check("hold");
    endtask

    task automatic test_async_reset();
        set_id(1'b1, 5'd11, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd12, 1'b1, 1'b0);
        step();
        hold  = 1'b1;
        flush = 1'b1;
        step();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (all_out !== 33'd0) begin
            failures++; $display("FAIL async_reset got %h required 0", all_out);
        end
        #1;
        rst   = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        exp_q.delete();
        exp_q.push_back({1'b1, 1'b0, 5'd13});
        set_id(1'b1, 5'd13, 1'b1, 1'b0);
        step();
        checks++;
        if ({e_valid, e_des_r} !== {1'b1, 5'd13}) begin
            failures++;
            $display("FAIL post_reset_capture got %b required %b", {e_valid, e_des_r}, {1'b1, 5'd13});
        end
        set_id(1'b0, 5'd0, 1'b0, 1'b0);
        drain_and_check("async_reset");
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_id(1'b1, 5'(20 + i), 1'b1, 1'b0);
            exp_q.push_back({1'b1, 1'b0, 5'(20 + i)});
            if (i == 3 || i == 7) begin
                stall = 1'b1;
                step();
                stall = 1'b0;
            end
            if (i == 5) begin
                hold = 1'b1;
                for (int h = 0; h < 3; h++) step();
                hold = 1'b0;
            end
            step();
        end
        set_id(1'b0, 5'd0, 1'b0, 1'b0);
        drain_and_check("perf");
        checks++;
        if ({retire_cnt, bubble_cnt, hold_cnt} !== {32'd10, 32'd2, 32'd3}) begin
            failures++;
            $display("FAIL perf_cnt got retire=%0d bubble=%0d hold=%0d required 10 2 3",
                     retire_cnt, bubble_cnt, hold_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_zero_reg();
        test_stall();
        test_hold_flush();
        test_async_reset();
`ifdef PIPE_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
